adc_idly_cal: RTL

- Automatic per-channel IDELAY calibration sequencer for the ADC data capture lanes.
- Serves channels one at a time in ascending index order. For each channel it:
  - sweeps all taps;
  - checks the captured ADC word against a fixed training pattern at every tap;
  - finds the longest passing window;
  - re-programs the delay line to the window centre.
- Sits between the housekeeping register block (start, mask, results) and the IDELAY primitives. It drives the rst/ce/inc strobes that software otherwise drives manually.

---
 rtl/adc_idly_cal.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_idly_cal.sv
`default_nettype none
// ============================================================================
//  Module      : adc_idly_cal
//  Description : Per-channel IDELAY calibration sequencer. Sweeps all 32 taps
//                of each selected channel, scores every tap against a fixed
//                training pattern, finds the longest passing window and
//                re-programs the delay line to the window centre.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_idly_cal #(
    parameter int              NCH    = 2,
    parameter int              NBIT   = 7,
    parameter int              DW     = 14,
    parameter logic [DW-1:0]   PAT    = 14'h2AAA,
    parameter int              SETTLE = 16,
    parameter int              NSAMP  = 256,
    parameter int              MINWIN = 4
) (
    input  logic                 clk_i,
    input  logic                 pll_ff_rst,
    input  logic                 start_i,
    input  logic [NCH-1:0]       chan_mask_i,
    input  logic [NCH*DW-1:0]    adc_dat_i,
    input  logic [NCH-1:0]       adc_vld_i,
    input  logic [NCH*5-1:0]     idly_cnt_i,
    output logic [NCH*NBIT-1:0]  idly_rst_o,
    output logic [NCH*NBIT-1:0]  idly_ce_o,
    output logic [NCH*NBIT-1:0]  idly_inc_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [NCH-1:0]       err_o,
    output logic [NCH*5-1:0]     tap_o,
    output logic [NCH*6-1:0]     win_o
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW = $clog2(NSAMP) + 1;
    localparam int TW = $clog2(SETTLE) + 1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RST    = 4'd1,
        S_SETTLE = 4'd2,
        S_CHECK  = 4'd3,
        S_EVAL   = 4'd4,
        S_CALC   = 4'd5,
        S_RST2   = 4'd6,
        S_MOVE   = 4'd7,
        S_MWAIT  = 4'd8,
        S_VERIFY = 4'd9
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [NCH-1:0]    r_mask;
    logic [CW-1:0]     r_ch;
    logic [4:0]        r_tap;
    logic [4:0]        r_step;
    logic [4:0]        r_centre;
    logic [4:0]        r_cur_start;
    logic [5:0]        r_cur_len;
    logic [4:0]        r_best_start;
    logic [5:0]        r_best_len;
    logic [SW-1:0]     r_scnt;
    logic [TW-1:0]     r_tcnt;
    logic              r_fail;

    logic [DW-1:0]     w_dat;
    logic              w_vld;
    logic [4:0]        w_cnt;
    logic [5:0]        w_new_len;
    logic              w_nxt_found;
    logic [CW-1:0]     w_nxt_ch;
    logic [CW-1:0]     w_first_ch;
    logic              w_settled;

    assign w_dat     = adc_dat_i[r_ch*DW +: DW];
    assign w_vld     = adc_vld_i[r_ch];
    assign w_cnt     = idly_cnt_i[r_ch*5 +: 5];
    assign w_new_len = r_cur_len + 6'd1;
    assign w_settled = (r_tcnt == TW'(SETTLE - 1));

    // Lowest masked channel above the current one, and lowest channel of a new mask
    always_comb begin
        w_nxt_found = 1'b0;
        w_nxt_ch    = '0;
        w_first_ch  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_ch))) begin
                w_nxt_found = 1'b1;
                w_nxt_ch    = CW'(i);
            end
            if (chan_mask_i[i]) begin
                w_first_ch = CW'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge pll_ff_rst) begin
        if (!pll_ff_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start_i && (chan_mask_i != '0)) w_state_nxt = S_RST;
            S_RST:    w_state_nxt = S_SETTLE;
            S_SETTLE: if (w_settled) w_state_nxt = S_CHECK;
            S_CHECK:  if (w_vld && (r_scnt == SW'(NSAMP - 1))) w_state_nxt = S_EVAL;
            S_EVAL:   w_state_nxt = (r_tap == 5'd31) ? S_CALC : S_SETTLE;
            S_CALC:   w_state_nxt = S_RST2;
            S_RST2:   w_state_nxt = S_MOVE;
            S_MOVE:   w_state_nxt = S_MWAIT;
            S_MWAIT:  if (w_settled) w_state_nxt = (r_step == r_centre) ? S_VERIFY : S_MOVE;
            S_VERIFY: w_state_nxt = w_nxt_found ? S_RST : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: counters, window trackers, registered strobes and results
    always_ff @(posedge clk_i or negedge pll_ff_rst) begin
        if (!pll_ff_rst) begin
            r_mask       <= '0;
            r_ch         <= '0;
            r_tap        <= '0;
            r_step       <= '0;
            r_centre     <= '0;
            r_cur_start  <= '0;
            r_cur_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
            r_scnt       <= '0;
            r_tcnt       <= '0;
            r_fail       <= 1'b0;
            idly_rst_o   <= '0;
            idly_ce_o    <= '0;
            idly_inc_o   <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= '0;
            tap_o        <= '0;
            win_o        <= '0;
        end else begin
            idly_rst_o <= '0;
            idly_ce_o  <= '0;
            idly_inc_o <= '0;
            done_o     <= 1'b0;

            // Wait counter runs only while dwelling in a settle state
            if (((r_state == S_SETTLE) || (r_state == S_MWAIT)) && (w_state_nxt == r_state)) begin
                r_tcnt <= r_tcnt + TW'(1);
            end else begin
                r_tcnt <= '0;
            end

            // Valid-sample counter for the current tap
            if (r_state == S_CHECK) begin
                if (w_vld) begin
                    r_scnt <= r_scnt + SW'(1);
                end
            end else begin
                r_scnt <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (chan_mask_i != '0) begin
                            r_mask <= chan_mask_i;
                            r_ch   <= w_first_ch;
                            busy_o <= 1'b1;
                            for (int i = 0; i < NCH; i++) begin
                                if (chan_mask_i[i]) begin
                                    err_o[i]       <= 1'b0;
                                    tap_o[i*5 +: 5] <= '0;
                                    win_o[i*6 +: 6] <= '0;
                                end
                            end
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                S_RST: begin
                    idly_rst_o[r_ch*NBIT +: NBIT] <= '1;
                    r_tap        <= '0;
                    r_cur_start  <= '0;
                    r_cur_len    <= '0;
                    r_best_start <= '0;
                    r_best_len   <= '0;
                end
                S_SETTLE: begin
                    r_fail <= 1'b0;
                end
                S_CHECK: begin
                    if (w_vld && (w_dat != PAT)) begin
                        r_fail <= 1'b1;
                    end
                end
                S_EVAL: begin
                    if (!r_fail) begin
                        if (r_cur_len == 6'd0) begin
                            r_cur_start <= r_tap;
                        end
                        r_cur_len <= w_new_len;
                        // Strictly greater keeps the earliest of equal windows
                        if (w_new_len > r_best_len) begin
                            r_best_start <= (r_cur_len == 6'd0) ? r_tap : r_cur_start;
                            r_best_len   <= w_new_len;
                        end
                    end else begin
                        r_cur_len <= '0;
                    end
                    if (r_tap != 5'd31) begin
                        idly_ce_o[r_ch*NBIT +: NBIT]  <= '1;
                        idly_inc_o[r_ch*NBIT +: NBIT] <= '1;
                        r_tap <= r_tap + 5'd1;
                    end
                end
                S_CALC: begin
                    if (r_best_len < 6'(MINWIN)) begin
                        err_o[r_ch] <= 1'b1;
                        r_centre    <= '0;
                    end else begin
                        r_centre <= r_best_start + r_best_len[5:1];
                    end
                    win_o[r_ch*6 +: 6] <= r_best_len;
                end
                S_RST2: begin
                    idly_rst_o[r_ch*NBIT +: NBIT] <= '1;
                    r_step <= '0;
                end
                S_MOVE: begin
                    if (r_step < r_centre) begin
                        idly_ce_o[r_ch*NBIT +: NBIT]  <= '1;
                        idly_inc_o[r_ch*NBIT +: NBIT] <= '1;
                        r_step <= r_step + 5'd1;
                    end
                end
                S_VERIFY: begin
                    if (w_cnt != r_centre) begin
                        err_o[r_ch] <= 1'b1;
                    end
                    tap_o[r_ch*5 +: 5] <= r_centre;
                    if (w_nxt_found) begin
                        r_ch <= w_nxt_ch;
                    end else begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
